// File: rtl/if_fetch_stage.sv
// if_fetch_stage: IF stage owning the PC, fetching over req/ack imem, feeding the hazard judger and IF/ID.
// Optional IF_PERF_CNT_EN adds saturating issue/stall performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] READY   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_q, buf_d, pend_addr_q, pend_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d, id_pc_q, id_pc_d, id_npc_q, id_npc_d;
  logic [31:0] pc_inc, target;
  logic        issue;
  assign pc_inc = pc_q + 32'd4;
  assign target = redirect_pc & ~32'd3;
  assign issue  = (state_q == READY) & ~if_stop & ~redirect_valid;
  assign imem_req  = ~rst & ((state_q != READY) | issue);
  assign imem_addr = (state_q == DISCARD) ? pend_addr_q : issue ? pc_inc : pc_q;
  assign if_valid  = state_q == READY;
  assign if_inst   = buf_q;
  assign if_pc     = pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_npc    = id_npc_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
          // an unanswered request must still be drained before the new fetch
          if (!imem_ack) begin
            pend_addr_d = pc_q;
            state_d     = DISCARD;
          end
        end else if (imem_ack) begin
          buf_d   = imem_rdata;
          state_d = READY;
        end
      end
      READY: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!if_stop) begin
          pc_d = pc_inc;
          if (imem_ack) buf_d = imem_rdata;
          else state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = target;
        else if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    id_valid_d = issue;
    id_inst_d  = issue ? buf_q : NOP_INST;
    id_pc_d    = issue ? pc_q : id_pc_q;
    id_npc_d   = issue ? pc_inc : id_npc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_q       <= 32'd0;
      pend_addr_q <= 32'd0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'd0;
      id_npc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      pend_addr_q <= pend_addr_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_npc_q    <= id_npc_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        stall;
  assign stall = (state_q == READY) & if_stop & ~redirect_valid;
  always_comb begin
    issue_cnt_d = (issue & ~&issue_cnt_q) ? issue_cnt_q + 32'd1 : issue_cnt_q;
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized bench for if_fetch_stage against a program-order reference model.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  logic        clk = 1'b0, rst = 1'b1, if_stop = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic        if_valid, id_valid;
  logic [31:0] if_inst, if_pc, id_inst, id_pc, id_npc;
  logic        w_req, w_ack, w_if_valid, w_id_valid;
  logic [31:0] w_addr, w_rdata, w_if_inst, w_if_pc, w_id_inst, w_id_pc, w_id_npc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt, w_perf_issue_cnt, w_perf_stall_cnt;
`endif
  int          vectors = 0, miscompares = 0, n_id = 0;
  logic [31:0] exp_pc, pend_addr, addr_s, m_issue, m_stall;
  logic        pend, req_s;
  always #5 clk = ~clk;
  if_fetch_stage dut (
    .clk(clk), .rst(rst), .if_stop(if_stop), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_npc(id_npc)
`ifdef IF_PERF_CNT_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  assign w_ack   = w_req;
  assign w_rdata = w_addr ^ 32'h1357_0000;
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .if_stop(1'b0), .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .if_valid(w_if_valid), .if_inst(w_if_inst), .if_pc(w_if_pc),
    .id_valid(w_id_valid), .id_inst(w_id_inst), .id_pc(w_id_pc), .id_npc(w_id_npc)
`ifdef IF_PERF_CNT_EN
    , .perf_issue_cnt(w_perf_issue_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0001 + ((a - RST_PC) >> 2);
  endfunction
  task automatic init_model();
    exp_pc = RST_PC; pend = 1'b0; pend_addr = 32'd0; m_issue = 32'd0; m_stall = 32'd0;
  endtask
  task automatic apply_reset();
    rst = 1'b1; if_stop = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_model();
  endtask
  // One clock of stimulus: drive, answer imem, and score the cycle against program order.
  task automatic step(input logic stop, input logic redir, input logic [31:0] rpc, input int ack_pct);
    logic v0, exp_idv;
    logic [31:0] pc0, inst0;
    @(negedge clk);
    if_stop = stop; redirect_valid = redir; redirect_pc = rpc;
    #1;
    req_s = imem_req; addr_s = imem_addr;
    if (pend) begin
      vectors++;
      if (!(imem_req === 1'b1 && imem_addr === pend_addr)) begin
        miscompares++;
        $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, pend_addr);
      end
    end
    imem_ack   = imem_req && ($urandom_range(0, 99) < ack_pct);
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    #1;
    v0 = if_valid; pc0 = if_pc; inst0 = if_inst;
    exp_idv = v0 & ~stop & ~redir;
    if (v0) begin
      vectors++;
      if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc)) begin
        miscompares++;
        $display("FAIL if_buf: pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_pc, mem_word(exp_pc));
      end
      vectors++;
      if (exp_idv ? (req_s !== 1'b1 || addr_s !== exp_pc + 32'd4) : (req_s !== 1'b0)) begin
        miscompares++;
        $display("FAIL ready_req: req=%b addr=%h, required req=%b addr=%h", req_s, addr_s, exp_idv, exp_pc + 32'd4);
      end
    end
    if (exp_idv && m_issue != 32'hFFFF_FFFF) m_issue++;
    if (v0 && stop && !redir && m_stall != 32'hFFFF_FFFF) m_stall++;
    pend = imem_req & ~imem_ack; pend_addr = imem_addr;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    if (id_valid === 1'b1) n_id++;
    vectors++;
    if (id_valid !== exp_idv) begin
      miscompares++;
      $display("FAIL id_valid: got %b, required %b", id_valid, exp_idv);
    end
    vectors++;
    if (exp_idv ? (id_pc !== exp_pc || id_inst !== mem_word(exp_pc) || id_npc !== exp_pc + 32'd4)
                : (id_inst !== 32'd0)) begin
      miscompares++;
      $display("FAIL id_reg: pc=%h inst=%h npc=%h, required pc=%h inst=%h npc=%h", id_pc, id_inst, id_npc,
               exp_pc, exp_idv ? mem_word(exp_pc) : 32'd0, exp_pc + 32'd4);
    end
    if (v0 && stop && !redir) begin
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== pc0 || if_inst !== inst0) begin
        miscompares++;
        $display("FAIL stall_hold: v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h", if_valid, if_pc, if_inst, pc0, inst0);
      end
    end
`ifdef IF_PERF_CNT_EN
    vectors++;
    if (perf_issue_cnt !== m_issue || perf_stall_cnt !== m_stall) begin
      miscompares++;
      $display("FAIL perf: issue=%0d stall=%0d, required issue=%0d stall=%0d", perf_issue_cnt, perf_stall_cnt, m_issue, m_stall);
    end
`endif
    if (redir) exp_pc = rpc & ~32'd3;
    else if (exp_idv) exp_pc = exp_pc + 32'd4;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; if_stop = 1'($urandom); redirect_valid = 1'($urandom); imem_ack = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: got %b, required 0", imem_req);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (if_valid !== 1'b0 || if_inst !== 32'd0 || id_valid !== 1'b0 || id_inst !== 32'd0 || id_pc !== 32'd0 || id_npc !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ifv=%b ifi=%h idv=%b idi=%h idpc=%h idnpc=%h, required all zero",
               if_valid, if_inst, id_valid, id_inst, id_pc, id_npc);
    end
`ifdef IF_PERF_CNT_EN
    vectors++;
    if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_perf: %h %h, required 0 0", perf_issue_cnt, perf_stall_cnt);
    end
`endif
    rst = 1'b0; if_stop = 1'b0; redirect_valid = 1'b0;
    init_model();
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      miscompares++; $display("FAIL reset_fetch: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RST_PC);
    end
  endtask
  task automatic test_zero_wait();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'd0, 100);
      vectors++;
      if (id_valid !== (k >= 1) || addr_s !== RST_PC + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL zero_wait[%0d]: idv=%b addr=%h, required idv=%b addr=%h", k, id_valid, addr_s, k >= 1, RST_PC + 32'(4 * k));
      end
    end
  endtask
  task automatic test_stall();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 32'd0, 100);
      vectors++;
      if (req_s !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'd0) begin
        miscompares++;
        $display("FAIL stall[%0d]: req=%b idv=%b idi=%h, required 0 0 0", k, req_s, id_valid, id_inst);
      end
    end
    step(1'b0, 1'b0, 32'd0, 100);
    vectors++;
    if (id_valid !== 1'b1) begin
      miscompares++; $display("FAIL stall_resume: idv=%b, required 1", id_valid);
    end
  endtask
  task automatic test_redirect_discard();
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 32'd0, 0);
    step(1'b0, 1'b1, 32'h0040_0100, 0);
    vectors++;
    if (if_valid !== 1'b0 || id_valid !== 1'b0) begin
      miscompares++; $display("FAIL redirect_fetch: ifv=%b idv=%b, required 0 0", if_valid, id_valid);
    end
    step(1'b0, 1'b0, 32'd0, 0);
    step(1'b0, 1'b0, 32'd0, 100);
    vectors++;
    if (addr_s !== RST_PC || id_valid !== 1'b0 || if_valid !== 1'b0) begin
      miscompares++; $display("FAIL discard_drain: addr=%h idv=%b ifv=%b, required addr=%h idv=0 ifv=0", addr_s, id_valid, if_valid, RST_PC);
    end
    step(1'b0, 1'b0, 32'd0, 100);
    vectors++;
    if (addr_s !== 32'h0040_0100) begin
      miscompares++; $display("FAIL discard_next: addr=%h, required 00400100", addr_s);
    end
    repeat (3) step(1'b0, 1'b0, 32'd0, 100);
  endtask
  task automatic test_redirect_stop();
    step(1'b1, 1'b1, 32'h0040_0202, 100);
    vectors++;
    if (req_s !== 1'b0 || id_valid !== 1'b0 || if_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_stop: req=%b idv=%b ifv=%b, required 0 0 0", req_s, id_valid, if_valid);
    end
    step(1'b0, 1'b0, 32'd0, 100);
    vectors++;
    if (addr_s !== 32'h0040_0200) begin
      miscompares++; $display("FAIL redir_stop_next: addr=%h, required 00400200", addr_s);
    end
    repeat (2) step(1'b0, 1'b0, 32'd0, 100);
  endtask
  task automatic test_wrap();
    apply_reset();
    @(negedge clk); #1;
    vectors++;
    if (w_addr !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_first: addr=%h, required fffffffc", w_addr);
    end
    @(negedge clk); #1;
    vectors++;
    if (w_addr !== 32'd0) begin
      miscompares++; $display("FAIL wrap_next: addr=%h, required 00000000", w_addr);
    end
    @(posedge clk); #1;
    vectors++;
    if (w_id_valid !== 1'b1 || w_id_pc !== 32'hFFFF_FFFC || w_id_npc !== 32'd0 || w_id_inst !== (32'hFFFF_FFFC ^ 32'h1357_0000)) begin
      miscompares++;
      $display("FAIL wrap_id: v=%b pc=%h npc=%h inst=%h, required 1 fffffffc 00000000 %h", w_id_valid, w_id_pc, w_id_npc, w_id_inst, 32'hFFFF_FFFC ^ 32'h1357_0000);
    end
  endtask
  task automatic test_random();
    int ack_pct;
    logic [31:0] rpc;
    apply_reset();
    n_id = 0;
    ack_pct = 100;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) ack_pct = $urandom_range(20, 100);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : RST_PC + 32'($urandom_range(0, 1023));
      step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8, rpc, ack_pct);
    end
    vectors++;
    if (n_id < 200) begin
      miscompares++; $display("FAIL random_progress: %0d issued, required at least 200", n_id);
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 32'd0, 100);
    step(1'b1, 1'b0, 32'd0, 100);
    repeat (2) step(1'b0, 1'b0, 32'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_req: got %b, required 0", imem_req);
    end
    @(posedge clk); #1;
`ifdef IF_PERF_CNT_EN
    vectors++;
    if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid_perf: %h %h, required 0 0", perf_issue_cnt, perf_stall_cnt);
    end
`endif
    rst = 1'b0;
    init_model();
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || id_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_restart: req=%b addr=%h idv=%b, required 1 %h 0", imem_req, imem_addr, id_valid, RST_PC);
    end
    repeat (4) step(1'b0, 1'b0, 32'd0, 100);
  endtask
  initial begin
    init_model();
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_discard();
    test_redirect_stop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
